// File: rtl/tetris_pkg.sv
// Shared types and helpers for the line-clear sequencer.
package tetris_pkg;
    localparam int GRID_ROWS = 22;
    localparam int GRID_COLS = 10;

    typedef logic [GRID_ROWS-1:0][GRID_COLS-1:0] grid_t;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_SCAN,
        CLR_SHIFT,
        CLR_COMMIT
    } clr_state_e;

    // Classic scoring; four or more lines all earn the tetris bonus.
    function automatic logic [10:0] line_points(input logic [4:0] k);
        case (k)
            5'd0:    line_points = 11'd0;
            5'd1:    line_points = 11'd40;
            5'd2:    line_points = 11'd100;
            5'd3:    line_points = 11'd300;
            default: line_points = 11'd1200;
        endcase
    endfunction
endpackage

// File: rtl/tetris_line_clear_ctrl_if.sv
// Game-FSM <-> line-clear sequencer signal bundle.
interface tetris_line_clear_ctrl_if #(
    parameter int ARRAY_ROWS = 22,
    parameter int COLS       = 10,
    parameter int SCORE_W    = 20
);
    logic                             start_i;
    logic                             new_game_i;
    logic [ARRAY_ROWS-1:0][COLS-1:0]  grid_i;
    logic [ARRAY_ROWS-1:0][COLS-1:0]  grid_o;
    logic                             grid_we_o;
    logic                             busy_o;
    logic                             done_o;
    logic [4:0]                       lines_cleared_o;
    logic [11:0]                      total_lines_o;
    logic [SCORE_W-1:0]               score_o;

    modport master (
        output start_i, new_game_i, grid_i,
        input  grid_o, grid_we_o, busy_o, done_o, lines_cleared_o, total_lines_o, score_o
    );
    modport slave (
        input  start_i, new_game_i, grid_i,
        output grid_o, grid_we_o, busy_o, done_o, lines_cleared_o, total_lines_o, score_o
    );
endinterface

// File: rtl/tetris_score_acc.sv
// Saturating score and running line-total accumulators.
module tetris_score_acc
    import tetris_pkg::*;
#(
    parameter int SCORE_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               commit,
    input  logic               clear,
    input  logic [4:0]         k,
    output logic [11:0]        total,
    output logic [SCORE_W-1:0] score
);
    logic [12:0]        total_sum;
    logic [SCORE_W:0]   score_sum;

    assign total_sum = {1'b0, total} + 13'(k);
    assign score_sum = {1'b0, score} + (SCORE_W+1)'(line_points(k));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            total <= '0;
            score <= '0;
        end else if (commit) begin
            total <= total_sum[12] ? '1 : total_sum[11:0];
            score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end
    end
endmodule

// File: rtl/tetris_line_clear_ctrl.sv
// Bottom-up full-row scan and collapse over a snapshot of the stored grid.
module tetris_line_clear_ctrl
    import tetris_pkg::*;
#(
    parameter int ROWS       = 20,
    parameter int ARRAY_ROWS = 22,
    parameter int COLS       = 10,
    parameter int SCORE_W    = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    tetris_line_clear_ctrl_if.slave    bus
);
    localparam int RW = $clog2(ROWS);

    clr_state_e                       state;
    logic [ARRAY_ROWS-1:0][COLS-1:0]  work;
    logic [RW-1:0]                    row;
    logic [4:0]                       k;
    logic [4:0]                       lines;
    logic                             commit;

    // new_game outranks the commit, so the strobe is masked in that cycle.
    assign commit             = (state == CLR_COMMIT) && !bus.new_game_i;
    assign bus.grid_o         = work;
    assign bus.grid_we_o      = commit;
    assign bus.done_o         = commit;
    assign bus.busy_o         = (state != CLR_IDLE);
    assign bus.lines_cleared_o = lines;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLR_IDLE;
            work  <= '0;
            row   <= '0;
            k     <= '0;
            lines <= '0;
        end else if (bus.new_game_i) begin
            state <= CLR_IDLE;
            lines <= '0;
        end else begin
            case (state)
                CLR_IDLE: if (bus.start_i) begin
                    work  <= bus.grid_i;
                    row   <= RW'(ROWS-1);
                    k     <= '0;
                    lines <= '0;
                    state <= CLR_SCAN;
                end
                CLR_SCAN: begin
                    if (&work[row])      state <= CLR_SHIFT;
                    else if (row == '0)  state <= CLR_COMMIT;
                    else                 row   <= row - 1'b1;
                end
                CLR_SHIFT: begin
                    // Collapse rows 0..row down by one; row is re-scanned next.
                    for (int i = 1; i < ROWS; i++)
                        if (i <= int'(row)) work[i] <= work[i-1];
                    work[0] <= '0;
                    k       <= (k == 5'd31) ? k : k + 1'b1;
                    state   <= CLR_SCAN;
                end
                CLR_COMMIT: begin
                    lines <= k;
                    state <= CLR_IDLE;
                end
                default: state <= CLR_IDLE;
            endcase
        end
    end

    tetris_score_acc #(.SCORE_W(SCORE_W)) u_score (
        .clk    (clk),
        .reset  (reset),
        .commit (commit),
        .clear  (bus.new_game_i),
        .k      (k),
        .total  (bus.total_lines_o),
        .score  (bus.score_o)
    );
endmodule

// File: tb/tb_tetris_line_clear_ctrl.sv
// Directed checks of the line-clear sequencer: latency, compaction, scoring, aborts.
module tb_tetris_line_clear_ctrl;
    import tetris_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tetris_line_clear_ctrl_if #(.ARRAY_ROWS(22), .COLS(10), .SCORE_W(20)) bus ();

    tetris_line_clear_ctrl #(.ROWS(20), .ARRAY_ROWS(22), .COLS(10), .SCORE_W(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a pass and wait for done; lat counts cycles after the start sample.
    task automatic do_pass(input grid_t g, output int lat, output grid_t gout, output logic we);
        int c;
        bus.grid_i  = g;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        c = 1;
        while (!bus.done_o && c < 200) begin
            tick();
            c++;
        end
        lat  = bus.done_o ? c : 999;
        gout = bus.grid_o;
        we   = bus.grid_we_o;
    endtask

    // Counts done pulses over n cycles.
    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.done_o || bus.grid_we_o) pulses++;
            tick();
        end
    endtask

    grid_t g, gout;
    int    lat, pulses;
    logic  we;

    initial begin
        bus.start_i    = 1'b0;
        bus.new_game_i = 1'b0;
        bus.grid_i     = '0;
        tick(); tick();
        reset = 1'b0;

        chk("rst_busy",  32'(bus.busy_o), 0);
        chk("rst_done",  32'(bus.done_o), 0);
        chk("rst_we",    32'(bus.grid_we_o), 0);
        chk("rst_score", 32'(bus.score_o), 0);
        chk("rst_total", 32'(bus.total_lines_o), 0);
        chk("rst_lines", 32'(bus.lines_cleared_o), 0);
        chk("rst_grid",  32'(bus.grid_o != '0), 0);

        // Empty grid
        g = '0;
        do_pass(g, lat, gout, we);
        chk("empty_lat",  32'(lat), 21);
        chk("empty_we",   32'(we), 1);
        chk("empty_grid", 32'(gout != '0), 0);
        tick();
        chk("empty_busy",  32'(bus.busy_o), 0);
        chk("empty_lines", 32'(bus.lines_cleared_o), 0);
        chk("empty_score", 32'(bus.score_o), 0);

        // Single line
        g = '0; g[19] = 10'h3FF; g[18] = 10'b0000110000;
        do_pass(g, lat, gout, we);
        chk("one_lat", 32'(lat), 23);
        chk("one_r19", 32'(gout[19]), 32'b0000110000);
        chk("one_r18", 32'(gout[18]), 0);
        tick();
        chk("one_lines", 32'(bus.lines_cleared_o), 1);
        chk("one_score", 32'(bus.score_o), 40);
        chk("one_total", 32'(bus.total_lines_o), 1);

        // Tetris
        g = '0; g[19] = '1; g[18] = '1; g[17] = '1; g[16] = '1; g[15] = 10'b1000000001;
        do_pass(g, lat, gout, we);
        chk("four_lat", 32'(lat), 29);
        chk("four_r19", 32'(gout[19]), 32'b1000000001);
        chk("four_r16_18", 32'({gout[18], gout[17], gout[16]}), 0);
        tick();
        chk("four_lines", 32'(bus.lines_cleared_o), 4);
        chk("four_score", 32'(bus.score_o), 1240);
        chk("four_total", 32'(bus.total_lines_o), 5);

        // Non-adjacent double
        g = '0; g[19] = '1; g[18] = 10'b0000000001; g[17] = '1; g[16] = 10'b1100000000;
        do_pass(g, lat, gout, we);
        chk("two_lat", 32'(lat), 25);
        chk("two_r19", 32'(gout[19]), 32'b0000000001);
        chk("two_r18", 32'(gout[18]), 32'b1100000000);
        tick();
        chk("two_lines", 32'(bus.lines_cleared_o), 2);
        chk("two_score", 32'(bus.score_o), 1340);

        // Top row full; hidden rows must pass through
        g = '0; g[0] = '1; g[20] = 10'h155; g[21] = 10'h2AA;
        do_pass(g, lat, gout, we);
        chk("top_lat", 32'(lat), 23);
        chk("top_r0",  32'(gout[0]), 0);
        chk("top_r20", 32'(gout[20]), 32'h155);
        chk("top_r21", 32'(gout[21]), 32'h2AA);
        tick();
        chk("top_lines", 32'(bus.lines_cleared_o), 1);
        chk("top_total", 32'(bus.total_lines_o), 8);

        // Whole playfield full
        g = '0;
        for (int i = 0; i < 20; i++) g[i] = '1;
        do_pass(g, lat, gout, we);
        chk("full_lat", 32'(lat), 61);
        chk("full_vis", 32'(gout[19:0] != '0), 0);
        tick();
        chk("full_lines", 32'(bus.lines_cleared_o), 20);
        chk("full_score", 32'(bus.score_o), 2580);
        chk("full_total", 32'(bus.total_lines_o), 28);

        // Extra start during a pass is ignored
        g = '0;
        bus.grid_i = g; bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        tick(); tick(); tick();
        bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        count_done(60, pulses);
        chk("dup_pulses", 32'(pulses), 1);
        chk("dup_busy",   32'(bus.busy_o), 0);

        // new_game aborts a pass and clears totals
        g = '0; g[19] = '1;
        bus.grid_i = g; bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        tick(); tick(); tick(); tick();
        bus.new_game_i = 1'b1; tick(); bus.new_game_i = 1'b0;
        chk("ng_busy",  32'(bus.busy_o), 0);
        chk("ng_score", 32'(bus.score_o), 0);
        chk("ng_total", 32'(bus.total_lines_o), 0);
        count_done(40, pulses);
        chk("ng_pulses", 32'(pulses), 0);

        // Reset mid-pass after building some score
        g = '0; g[19] = '1;
        do_pass(g, lat, gout, we);
        tick();
        chk("pre_rst_score", 32'(bus.score_o), 40);
        bus.grid_i = g; bus.start_i = 1'b1; tick(); bus.start_i = 1'b0;
        tick(); tick(); tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("mid_rst_busy",  32'(bus.busy_o), 0);
        chk("mid_rst_score", 32'(bus.score_o), 0);
        chk("mid_rst_total", 32'(bus.total_lines_o), 0);
        chk("mid_rst_lines", 32'(bus.lines_cleared_o), 0);
        chk("mid_rst_grid",  32'(bus.grid_o != '0), 0);
        count_done(40, pulses);
        chk("mid_rst_pulses", 32'(pulses), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/tetris_line_clear_ctrl.md
Name: tetris_line_clear_ctrl

Overview:
Sequencer that runs after a landed piece has been merged into the permanent grid. On a start pulse it snapshots the grid and scans the playfield bottom-up, one row per cycle. Each full row is removed by shifting every row above it down one. It then writes the compacted grid back with a one-cycle write strobe and updates the score and line counters. It sits between the game FSM (which issues start in its LANDED handling and waits for done before SPAWN) and the stored-grid register.

Parameters:
- ROWS, 20, visible playfield rows scanned (rows 0..ROWS-1; row 0 is the top).
- ARRAY_ROWS, 22, total grid rows; rows ROWS..ARRAY_ROWS-1 pass through untouched.
- COLS, 10, columns per row.
- SCORE_W, 20, score counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start_i  in  1  single-cycle request to run a clear pass on grid_i
- new_game_i  in  1  clears score/line totals; aborts any pass in progress
- grid_i  in  ARRAY_ROWS x COLS  stored grid, sampled only on an accepted start
- grid_o  out  ARRAY_ROWS x COLS  compacted grid; valid while grid_we_o=1
- grid_we_o  out  1  one-cycle write strobe for the stored grid
- busy_o  out  1  pass in progress
- done_o  out  1  one-cycle pulse, coincident with grid_we_o
- lines_cleared_o  out  5  rows removed by the last pass; held until the next accepted start
- total_lines_o  out  12  saturating running total of cleared lines
- score_o  out  SCORE_W  saturating running score

Behaviour:
- Reset: all outputs 0, state IDLE, working grid 0, row index 0.
- States: IDLE, SCAN, SHIFT, COMMIT.
- IDLE: on start_i=1 (and new_game_i=0):
  - work <= grid_i, row <= ROWS-1, k <= 0, lines_cleared_o <= 0, next state SCAN.
  - busy_o is high from the next cycle.
- SCAN (evaluates work[row]):
  - If row is all ones, go to SHIFT.
  - Else if row==0, go to COMMIT.
  - Else row <= row-1.
- SHIFT, for the current row r:
  - work[i] <= work[i-1] for i=r..1; work[0] <= 0; rows >= ROWS unchanged.
  - k <= k+1 (saturate at 31); return to SCAN with the same row, so the row shifted in is re-checked.
- COMMIT:
  - grid_we_o=1, done_o=1, grid_o=work, lines_cleared_o <= k.
  - total_lines_o <= total_lines_o + k, saturating at 4095.
  - score_o <= score_o + pts(k), saturating at all-ones. pts: 0->0, 1->40, 2->100, 3->300, 4 or more->1200.
  - Next state IDLE; busy_o low from the next cycle.
- Latency: done_o asserts exactly ROWS+2k+1 cycles after the cycle start_i was sampled. Example: 21 cycles for k=0, 23 cycles for k=1 at ROWS=20.
- start_i while busy_o=1 is ignored; no queuing.
- start_i in the COMMIT cycle is ignored; it is accepted in the next IDLE cycle.
- grid_o outside the grid_we_o cycle: holds work. Consumers use it only with the strobe.
- Full top row (row 0): shifted out normally; 0 is shifted in.
- Whole playfield full: k=ROWS, every visible row ends at 0, pts=1200.
- Rows ROWS..ARRAY_ROWS-1 are never scanned or modified.
- new_game_i=1 in any state:
  - score_o <= 0, total_lines_o <= 0, lines_cleared_o <= 0, state IDLE.
  - No grid_we_o/done_o that cycle; a pass in progress is discarded.
  - It has priority over start_i and over COMMIT.
- reset mid-pass: synchronous return to IDLE with all outputs 0 on the next edge; no write strobe.

Decomposition:
- tetris_pkg holds:
  - GRID_ROWS/COLS constants
  - typedef grid_t (logic [21:0][9:0])
  - clear-state enum
  - function line_points(k) implementing the pts table
- One natural sub-module, tetris_score_acc: the saturating score and total-lines accumulators, fed by k plus a commit strobe and a new-game clear.
- The scan/shift FSM stays in the top.

Test Plan:
- Empty grid, start -> done_o and grid_we_o together 21 cycles later; grid_o=0; lines_cleared_o=0; score_o stays 0.
- Row 19 all ones, row 18=10'b0000110000, start -> done at cycle 23:
  - grid_o[19]=10'b0000110000, grid_o[18]=0
  - lines_cleared_o=1, score_o=40, total_lines_o=1
- Rows 16..19 full and row 15=10'b1000000001 -> done at cycle 29:
  - grid_o[19]=10'b1000000001, rows 16..18=0
  - lines_cleared_o=4, score_o += 1200
- Rows 19 and 17 full, row 18=10'b0000000001, row 16=10'b1100000000 -> done at cycle 25:
  - grid_o[19]=10'b0000000001, grid_o[18]=10'b1100000000
  - k=2, score += 100
- Rows 20..21 preloaded nonzero, row 0 full -> row 0 cleared, rows 20..21 unchanged, k=1.
- Abort and ignore cases:
  - start, then new_game_i at cycle 5 -> no done/grid_we ever, score_o=0, busy_o=0 next cycle.
  - start_i pulsed during a pass -> ignored; only one done pulse.
  - reset asserted mid-pass -> all outputs 0 next cycle.
